dram_req_arbiter: RTL and testbench

- Shares one DRAM port between NReq requesters. Downstream is a SynthesizedDRAM or a SynthesizedRandDRAM instance.
- Arbitrates commands round-robin.
- Records the issue order of reads and writes in two ID FIFOs.
- Uses those FIFOs to steer write-data beats from the right requester and to route read-return beats back to the right requester. The DRAM returns data in order.

---
 rtl/dram_req_arbiter_pkg.sv | 15 +
 rtl/dram_arb_order_fifo.sv | 51 +++++
 rtl/dram_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_dram_req_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_req_arbiter_pkg.sv
// rtl/dram_req_arbiter_pkg.sv - DRAM command codes and sizing helpers for the request arbiter
package dram_req_arbiter_pkg;

  localparam int DRAMCMD_CWidth = 3;

  localparam logic [DRAMCMD_CWidth-1:0] DRAMCMD_Read    = 3'd1;
  localparam logic [DRAMCMD_CWidth-1:0] DRAMCMD_Write   = 3'd2;
  localparam logic [DRAMCMD_CWidth-1:0] DRAMCMD_Refresh = 3'd3;

  // Bits needed to hold an index in 0..n-1; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_arb_order_fifo.sv
// rtl/dram_arb_order_fifo.sv - small FIFO recording requester ids in DRAM issue order
module dram_arb_order_fifo #(
  parameter int Width = 1,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PtrW+1)'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full FIFO refuses the push even when it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy tracking; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; slots are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// rtl/dram_req_arbiter.sv - round-robin sharing of one DRAM port; optional stats under DRAM_ARB_STATS_EN
module dram_req_arbiter
  import dram_req_arbiter_pkg::*;
#(
  parameter int NReq     = 2,
  parameter int AWidth   = 12,
  parameter int DWidth   = 9,
  parameter int MWidth   = 1,
  parameter int BurstLen = 1,
  parameter int OrdDepth = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NReq*DRAMCMD_CWidth-1:0] req_command,
  input  logic [NReq*AWidth-1:0]         req_address,
  input  logic [NReq-1:0]                req_command_valid,
  output logic [NReq-1:0]                req_command_ready,
  input  logic [NReq*DWidth-1:0]         req_data_in,
  input  logic [NReq*MWidth-1:0]         req_data_in_mask,
  input  logic [NReq-1:0]                req_data_in_valid,
  output logic [NReq-1:0]                req_data_in_ready,
  output logic [DWidth-1:0]              req_data_out,
  output logic [NReq-1:0]                req_data_out_valid,
  input  logic [NReq-1:0]                req_data_out_ready,
  output logic [DRAMCMD_CWidth-1:0]      command,
  output logic [AWidth-1:0]              command_address,
  output logic                           command_valid,
  input  logic                           command_ready,
  output logic [DWidth-1:0]              data_in,
  output logic [MWidth-1:0]              data_in_mask,
  output logic                           data_in_valid,
  input  logic                           data_in_ready,
  input  logic [DWidth-1:0]              data_out,
  input  logic                           data_out_valid,
  output logic                           data_out_ready
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [NReq*32-1:0]             stat_grants,
  output logic [31:0]                    stat_stall
`endif
);

  localparam int IdW  = id_width(NReq);
  localparam int CntW = $clog2(BurstLen) + 1;

  logic [IdW-1:0]            rr;
  logic [IdW-1:0]            grant;
  logic                      found;
  logic [NReq-1:0]           eligible;
  logic [DRAMCMD_CWidth-1:0] grant_cmd;
  logic                      issue;
  logic                      rd_full, rd_empty, wr_full, wr_empty;
  logic [IdW-1:0]            rd_head, wr_head;
  logic                      rd_push, wr_push, rd_pop, wr_pop;
  logic                      wr_beat, rd_beat, wr_last, rd_last;
  logic [CntW-1:0]           wcnt, rcnt;

  // A requester may compete only if its command has room in its order FIFO.
  always_comb begin
    eligible = '1;
    for (int i = 0; i < NReq; i++) begin
      if (req_command[i*DRAMCMD_CWidth +: DRAMCMD_CWidth] == DRAMCMD_Read)
        eligible[i] = ~rd_full;
      else if (req_command[i*DRAMCMD_CWidth +: DRAMCMD_CWidth] == DRAMCMD_Write)
        eligible[i] = ~wr_full;
    end
  end

  // Round-robin search from rr for the first valid, eligible requester.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NReq; k++) begin
      idx = int'(rr) + k;
      if (idx >= NReq) idx = idx - NReq;
      if (!found && req_command_valid[idx] && eligible[idx]) begin
        found = 1'b1;
        grant = IdW'(idx);
      end
    end
  end

  assign grant_cmd         = req_command[grant*DRAMCMD_CWidth +: DRAMCMD_CWidth];
  assign command_valid     = found;
  assign command           = found ? grant_cmd : '0;
  assign command_address   = found ? req_address[grant*AWidth +: AWidth] : '0;
  assign req_command_ready = (found && command_ready) ? (NReq'(1) << grant) : '0;
  assign issue             = found & command_ready;
  assign rd_push           = issue && (grant_cmd == DRAMCMD_Read);
  assign wr_push           = issue && (grant_cmd == DRAMCMD_Write);

  // Pointer moves just past the requester that issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr <= '0;
    else if (issue) rr <= (int'(grant) == NReq - 1) ? '0 : grant + 1'b1;
  end

  dram_arb_order_fifo #(.Width(IdW), .Depth(OrdDepth)) u_rd_order (
    .clk(clk), .rst_n(rst_n), .push(rd_push), .push_data(grant), .pop(rd_pop),
    .full(rd_full), .empty(rd_empty), .head(rd_head)
  );

  dram_arb_order_fifo #(.Width(IdW), .Depth(OrdDepth)) u_wr_order (
    .clk(clk), .rst_n(rst_n), .push(wr_push), .push_data(grant), .pop(wr_pop),
    .full(wr_full), .empty(wr_empty), .head(wr_head)
  );

  // Write beats come only from the requester at the head of the write order.
  assign data_in_valid     = ~wr_empty & req_data_in_valid[wr_head];
  assign req_data_in_ready = wr_empty ? '0 : (NReq'(data_in_ready) << wr_head);
  assign data_in           = wr_empty ? '0 : req_data_in[wr_head*DWidth +: DWidth];
  assign data_in_mask      = wr_empty ? '0 : req_data_in_mask[wr_head*MWidth +: MWidth];
  assign wr_beat           = data_in_valid & data_in_ready;
  assign wr_last           = (wcnt == CntW'(BurstLen - 1));
  assign wr_pop            = wr_beat & wr_last;

  // Read beats return in issue order; with no outstanding read they stall.
  assign req_data_out       = data_out;
  assign req_data_out_valid = rd_empty ? '0 : (NReq'(data_out_valid) << rd_head);
  assign data_out_ready     = ~rd_empty & req_data_out_ready[rd_head];
  assign rd_beat            = data_out_valid & data_out_ready;
  assign rd_last            = (rcnt == CntW'(BurstLen - 1));
  assign rd_pop             = rd_beat & rd_last;

  // Burst beat counters; the last beat clears the count and retires the order entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      if (wr_beat) wcnt <= wr_last ? '0 : wcnt + 1'b1;
      if (rd_beat) rcnt <= rd_last ? '0 : rcnt + 1'b1;
    end
  end

`ifdef DRAM_ARB_STATS_EN
  // Saturating per-requester grant counters and command-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NReq; i++) begin
        if (issue && int'(grant) == i && stat_grants[i*32 +: 32] != '1)
          stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
      if (command_valid && !command_ready && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb/tb_dram_req_arbiter.sv - directed self-checking bench for dram_req_arbiter (NReq=2, BurstLen=2)
module tb_dram_req_arbiter;
  import dram_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  req_command;
  logic [23:0] req_address;
  logic [1:0]  req_command_valid, req_command_ready;
  logic [17:0] req_data_in;
  logic [1:0]  req_data_in_mask;
  logic [1:0]  req_data_in_valid, req_data_in_ready;
  logic [8:0]  req_data_out;
  logic [1:0]  req_data_out_valid, req_data_out_ready;
  logic [2:0]  command;
  logic [11:0] command_address;
  logic        command_valid, command_ready;
  logic [8:0]  data_in;
  logic [0:0]  data_in_mask;
  logic        data_in_valid, data_in_ready;
  logic [8:0]  data_out;
  logic        data_out_valid, data_out_ready;
`ifdef DRAM_ARB_STATS_EN
  logic [63:0] stat_grants;
  logic [31:0] stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  logic [1:0] rd_pattern [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

  dram_req_arbiter #(
    .NReq(2), .AWidth(12), .DWidth(9), .MWidth(1), .BurstLen(2), .OrdDepth(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_command(req_command), .req_address(req_address),
    .req_command_valid(req_command_valid), .req_command_ready(req_command_ready),
    .req_data_in(req_data_in), .req_data_in_mask(req_data_in_mask),
    .req_data_in_valid(req_data_in_valid), .req_data_in_ready(req_data_in_ready),
    .req_data_out(req_data_out), .req_data_out_valid(req_data_out_valid),
    .req_data_out_ready(req_data_out_ready),
    .command(command), .command_address(command_address),
    .command_valid(command_valid), .command_ready(command_ready),
    .data_in(data_in), .data_in_mask(data_in_mask),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef DRAM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_command = '0; req_address = '0; req_command_valid = '0;
    req_data_in = '0; req_data_in_mask = '0; req_data_in_valid = '0;
    req_data_out_ready = '0; command_ready = 1'b0; data_in_ready = 1'b0;
    data_out = 9'h1a5; data_out_valid = 1'b0;
    tick(); tick();
    check("rst_cmd_valid", 64'(command_valid), 64'd0);
    check("rst_cmd_ready", 64'(req_command_ready), 64'd0);
    check("rst_din_valid", 64'(data_in_valid), 64'd0);
    check("rst_din_ready", 64'(req_data_in_ready), 64'd0);
    check("rst_dout_ready", 64'(data_out_ready), 64'd0);
    check("rst_dout_valid", 64'(req_data_out_valid), 64'd0);
    check("rst_passthru", 64'(req_data_out), 64'h1a5);
    rst_n = 1'b1;

    // Continuous reads from both requesters alternate grants.
    req_command = {DRAMCMD_Read, DRAMCMD_Read};
    req_address = {12'h200, 12'h100};
    req_command_valid = 2'b11;
    command_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #2;
      check($sformatf("rr_grant%0d", n), 64'(req_command_ready), (n % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("rr_addr%0d", n), 64'(command_address), (n % 2 == 0) ? 64'h100 : 64'h200);
      tick();
    end
    req_command_valid = 2'b00;
    req_data_out_ready = 2'b11;
    data_out_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      data_out = 9'(n + 3);
      #2;
      check($sformatf("rd_steer%0d", n), 64'(req_data_out_valid), 64'(rd_pattern[n]));
      check($sformatf("rd_data%0d", n), 64'(req_data_out), 64'(n + 3));
      tick();
    end

    // Unsolicited read data stalls until a read is issued.
    #2;
    check("unsol_ready", 64'(data_out_ready), 64'd0);
    check("unsol_valid", 64'(req_data_out_valid), 64'd0);
    req_command_valid = 2'b10;
    #2;
    check("unsol_issue", 64'(req_command_ready), 64'd2);
    tick();
    req_command_valid = 2'b00;
    #2;
    check("unsol_route", 64'(req_data_out_valid), 64'd2);
    check("unsol_accept", 64'(data_out_ready), 64'd1);
    tick();
    tick();
    #2;
    check("unsol_done", 64'(req_data_out_valid), 64'd0);
    data_out_valid = 1'b0;

    // Req1 writes 0x010, then req0 reads 0x010.
    req_command = {DRAMCMD_Write, DRAMCMD_Read};
    req_address = {12'h010, 12'h010};
    req_command_valid = 2'b10;
    #2;
    check("wr_issue", 64'(req_command_ready), 64'd2);
    check("wr_cmd", 64'(command), 64'(DRAMCMD_Write));
    tick();
    req_command_valid = 2'b01;
    #2;
    check("rd_issue", 64'(req_command_ready), 64'd1);
    check("rd_addr", 64'(command_address), 64'h010);
    tick();
    req_command_valid = 2'b00;
    req_data_in = {9'h155, 9'h0aa};
    req_data_in_valid = 2'b11;
    data_in_ready = 1'b1;
    #2;
    check("wbeat0_valid", 64'(data_in_valid), 64'd1);
    check("wbeat0_ready", 64'(req_data_in_ready), 64'd2);
    check("wbeat0_data", 64'(data_in), 64'h155);
    tick();
    req_data_in = {9'h0f0, 9'h0aa};
    #2;
    check("wbeat1_ready", 64'(req_data_in_ready), 64'd2);
    check("wbeat1_data", 64'(data_in), 64'h0f0);
    tick();
    #2;
    check("wdone_valid", 64'(data_in_valid), 64'd0);
    check("wdone_ready", 64'(req_data_in_ready), 64'd0);
    data_out = 9'h033;
    data_out_valid = 1'b1;
    #2;
    check("rret0", 64'(req_data_out_valid), 64'd1);
    tick();
    #2;
    check("rret1", 64'(req_data_out_valid), 64'd1);
    tick();
    #2;
    check("rret_done", 64'(req_data_out_valid), 64'd0);
    data_out_valid = 1'b0;
    req_data_in_valid = 2'b00;
    data_in_ready = 1'b0;

    // Read FIFO fills; req0 blocks while req1 writes proceed.
    req_command_valid = 2'b01;
    for (int n = 0; n < 8; n++) begin
      #2;
      check($sformatf("fill%0d", n), 64'(req_command_ready), 64'd1);
      tick();
    end
    #2;
    check("full_valid", 64'(command_valid), 64'd0);
    check("full_ready", 64'(req_command_ready), 64'd0);
    req_command_valid = 2'b11;
    #2;
    check("full_skip", 64'(req_command_ready), 64'd2);
    tick();
    req_command_valid = 2'b01;
    data_out_valid = 1'b1;
    #2;
    check("full_beat0", 64'(command_valid), 64'd0);
    tick();
    #2;
    check("full_beat1", 64'(command_valid), 64'd0);
    tick();
    data_out_valid = 1'b0;
    #2;
    check("full_freed", 64'(req_command_ready), 64'd1);
    tick();
    req_command = {DRAMCMD_Write, DRAMCMD_Refresh};
    #2;
    check("other_cmd", 64'(req_command_ready), 64'd1);
    tick();
    req_command_valid = 2'b00;

    // Reset in the middle of req1's write burst.
    req_data_in_valid = 2'b10;
    data_in_ready = 1'b1;
    #2;
    check("mid_beat0", 64'(data_in_valid), 64'd1);
    tick();
    rst_n = 1'b0;
    data_out_valid = 1'b1;
    #2;
    check("mid_rst_din", 64'(data_in_valid), 64'd0);
    check("mid_rst_dready", 64'(req_data_in_ready), 64'd0);
    check("mid_rst_dout", 64'(req_data_out_valid), 64'd0);
    check("mid_rst_cmd", 64'(command_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    req_command = {DRAMCMD_Read, DRAMCMD_Read};
    req_command_valid = 2'b11;
    #2;
    check("post_rst_grant", 64'(req_command_ready), 64'd1);
    check("post_rst_wempty", 64'(data_in_valid), 64'd0);
    check("post_rst_rempty", 64'(req_data_out_valid), 64'd0);
    req_command_valid = 2'b00;
    data_out_valid = 1'b0;
    data_in_ready = 1'b0;
    req_data_in_valid = 2'b00;

`ifdef DRAM_ARB_STATS_EN
    req_command = {DRAMCMD_Refresh, DRAMCMD_Refresh};
    command_ready = 1'b1;
    req_command_valid = 2'b01;
    repeat (5) tick();
    req_command_valid = 2'b10;
    repeat (3) tick();
    req_command_valid = 2'b01;
    command_ready = 1'b0;
    repeat (4) tick();
    req_command_valid = 2'b00;
    #2;
    check("stat_grants", stat_grants, {32'd3, 32'd5});
    check("stat_stall", 64'(stat_stall), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
